// File: rtl/plab3_mem_dual_port_mem_arbiter.sv
// Merges icache (port 0) and dcache (port 1) memory request streams onto one in-order
// memory port; a source-ID FIFO routes responses back. PLAB3_MEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority.
module plab3_mem_dual_port_mem_arbiter #(
   parameter  int p_max_outstanding = 4,
   localparam int abw               = 32,
   localparam int clw               = 128,
   localparam int req_nbits         = 3 + 8 + abw + $clog2(clw/8) + clw,
   localparam int resp_nbits        = 3 + 8 + $clog2(clw/8) + clw
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic [req_nbits-1:0]  req0_msg,
   input  logic                  req0_val,
   output logic                  req0_rdy,

   input  logic [req_nbits-1:0]  req1_msg,
   input  logic                  req1_val,
   output logic                  req1_rdy,

   output logic [resp_nbits-1:0] resp0_msg,
   output logic                  resp0_val,
   input  logic                  resp0_rdy,

   output logic [resp_nbits-1:0] resp1_msg,
   output logic                  resp1_val,
   input  logic                  resp1_rdy,

   output logic [req_nbits-1:0]  memreq_msg,
   output logic                  memreq_val,
   input  logic                  memreq_rdy,

   input  logic [resp_nbits-1:0] memresp_msg,
   input  logic                  memresp_val,
   output logic                  memresp_rdy
);

   localparam int ptr_w = $clog2(p_max_outstanding);

   logic             id_fifo_r [p_max_outstanding];
   logic [ptr_w-1:0] head_r;
   logic [ptr_w-1:0] tail_r;
   logic [ptr_w:0]   count_r;

   logic             rr_ptr_s;
   logic             grant_val_s;
   logic             grant_id_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic             head_id_s;
   logic             push_s;
   logic             pop_s;

`ifdef PLAB3_MEM_ARB_FIXED_PRIO_EN
   assign rr_ptr_s = 1'b0;
`else
   logic rr_ptr_r;

   // Round-robin pointer: after a fire the other port wins the next conflict
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr_r <= 1'b0;
      end else if (push_s) begin
         rr_ptr_r <= ~grant_id_s;
      end
   end

   assign rr_ptr_s = rr_ptr_r;
`endif

   // Grant depends only on the two valids and the pointer, never on memreq_rdy
   always_comb begin
      grant_val_s = 1'b0;
      grant_id_s  = 1'b0;
      if (req0_val && req1_val) begin
         grant_val_s = 1'b1;
         grant_id_s  = rr_ptr_s;
      end else if (req0_val) begin
         grant_val_s = 1'b1;
         grant_id_s  = 1'b0;
      end else if (req1_val) begin
         grant_val_s = 1'b1;
         grant_id_s  = 1'b1;
      end else begin
         grant_val_s = 1'b0;
         grant_id_s  = 1'b0;
      end
   end

   assign fifo_full_s  = (count_r == (ptr_w+1)'(p_max_outstanding));
   assign fifo_empty_s = (count_r == {(ptr_w+1){1'b0}});
   assign head_id_s    = id_fifo_r[head_r];

   // val/rdy outputs are gated by reset so they drop the moment reset asserts
   assign memreq_msg  = grant_id_s ? req1_msg : req0_msg;
   assign memreq_val  = reset && grant_val_s && !fifo_full_s;
   assign req0_rdy    = reset && grant_val_s && !grant_id_s && memreq_rdy && !fifo_full_s;
   assign req1_rdy    = reset && grant_val_s &&  grant_id_s && memreq_rdy && !fifo_full_s;

   assign resp0_msg   = memresp_msg;
   assign resp1_msg   = memresp_msg;
   assign resp0_val   = reset && memresp_val && !fifo_empty_s && !head_id_s;
   assign resp1_val   = reset && memresp_val && !fifo_empty_s &&  head_id_s;
   assign memresp_rdy = reset && !fifo_empty_s && (head_id_s ? resp1_rdy : resp0_rdy);

   assign push_s = memreq_val && memreq_rdy;
   assign pop_s  = memresp_val && memresp_rdy;

   // Source-ID FIFO; head/tail wrap naturally because the depth is a power of two
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_r  <= {ptr_w{1'b0}};
         tail_r  <= {ptr_w{1'b0}};
         count_r <= {(ptr_w+1){1'b0}};
         for (int i = 0; i < p_max_outstanding; i++) begin
            id_fifo_r[i] <= 1'b0;
         end
      end else begin
         if (push_s) begin
            id_fifo_r[tail_r] <= grant_id_s;
            tail_r            <= tail_r + ptr_w'(1);
         end
         if (pop_s) begin
            head_r <= head_r + ptr_w'(1);
         end
         if (push_s && !pop_s) begin
            count_r <= count_r + (ptr_w+1)'(1);
         end else if (pop_s && !push_s) begin
            count_r <= count_r - (ptr_w+1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_plab3_mem_dual_port_mem_arbiter.sv
// Self-checking bench for plab3_mem_dual_port_mem_arbiter: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_plab3_mem_dual_port_mem_arbiter;
   localparam int DEPTH  = 4;
   localparam int REQ_W  = 175;
   localparam int RESP_W = 143;

   logic              clk = 1'b0;
   logic              reset;
   logic [REQ_W-1:0]  req0_msg, req1_msg, memreq_msg;
   logic              req0_val, req0_rdy, req1_val, req1_rdy;
   logic [RESP_W-1:0] resp0_msg, resp1_msg, memresp_msg;
   logic              resp0_val, resp0_rdy, resp1_val, resp1_rdy;
   logic              memreq_val, memreq_rdy, memresp_val, memresp_rdy;

   int total = 0;
   int bad   = 0;

   // reference model: outstanding source IDs in issue order, memory response queue, conflict winner
   int                q_ids[$];
   logic [RESP_W-1:0] mem_q[$];
   int                rr;

   always #5 clk = ~clk;

   plab3_mem_dual_port_mem_arbiter #(.p_max_outstanding(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
      .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
      .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
      .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
      .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
      .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy)
   );

   function automatic logic [REQ_W-1:0] rand_req();
      logic [191:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[REQ_W-1:0];
   endfunction

   function automatic logic [RESP_W-1:0] make_resp(logic [REQ_W-1:0] rq);
      return {rq[174:172], rq[171:164], rq[131:128], rq[127:0] ^ 128'h5a5a_1234_0000_ffff_c3c3_9876_0f0f_abcd};
   endfunction

   // winner of the current cycle: -1 when no port is valid
   function automatic int exp_grant(logic v0, logic v1);
      if (v0 && v1) return rr;
      else if (v0) return 0;
      else if (v1) return 1;
      else return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req0_val = 1'b0; req1_val = 1'b0; memreq_rdy = 1'b0;
      memresp_val = 1'b0; resp0_rdy = 1'b0; resp1_rdy = 1'b0;
      req0_msg = '0; req1_msg = '0; memresp_msg = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clear_inputs();
      q_ids.delete();
      mem_q.delete();
      rr = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_reset();
      logic [5:0] obs;
      clear_inputs();
      reset = 1'b0;
      req0_val = 1'b1; req1_val = 1'b1; memreq_rdy = 1'b1;
      memresp_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
      #3;
      obs = {memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy};
      total++;
      if (obs !== 6'b000000) begin
         bad++; $display("FAIL reset_outputs got=%b exp=%b", obs, 6'b000000);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      req0_val = 1'b0; req1_val = 1'b0;
      @(negedge clk);
      obs = {memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy};
      total++;
      if (obs !== 6'b000000) begin
         bad++; $display("FAIL reset_empty_hold got=%b exp=%b", obs, 6'b000000);
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_single();
      logic [REQ_W-1:0]  rq;
      logic [RESP_W-1:0] rs;
      do_reset();
      rq = {3'd0, 8'h11, 32'h0000_1000, 4'd0, 128'd0};
      rs = {3'd0, 8'h11, 4'd0, 128'h0000_0000_0000_0000_0000_0000_0000_dead};
      req0_msg = rq; req0_val = 1'b1; memreq_rdy = 1'b1;
      @(negedge clk);
      total++;
      if ({memreq_val, req0_rdy, req1_rdy} !== 3'b110 || memreq_msg !== rq) begin
         bad++; $display("FAIL single_req got=%b msg=%h exp=110 msg=%h", {memreq_val, req0_rdy, req1_rdy}, memreq_msg, rq);
      end
      tick();
      req0_val = 1'b0;
      memresp_val = 1'b1; memresp_msg = rs; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
      @(negedge clk);
      total++;
      if ({resp0_val, resp1_val, memresp_rdy} !== 3'b101 || resp0_msg !== rs) begin
         bad++; $display("FAIL single_resp got=%b msg=%h exp=101 msg=%h", {resp0_val, resp1_val, memresp_rdy}, resp0_msg, rs);
      end
      tick();
      @(negedge clk);
      total++;
      if ({resp0_val, resp1_val, memresp_rdy} !== 3'b000) begin
         bad++; $display("FAIL single_drained got=%b exp=000", {resp0_val, resp1_val, memresp_rdy});
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_conflict();
      logic [REQ_W-1:0] m0, m1;
      do_reset();
      m0 = rand_req(); m1 = rand_req();
      req0_msg = m0; req1_msg = m1; req0_val = 1'b1; req1_val = 1'b1; memreq_rdy = 1'b1;
      @(negedge clk);
      total++;
      if ({req0_rdy, req1_rdy} !== 2'b10 || memreq_msg !== m0) begin
         bad++; $display("FAIL conflict_c0 got=%b exp=10", {req0_rdy, req1_rdy});
      end
      tick();
      req0_val = 1'b0;
      @(negedge clk);
      total++;
      if ({memreq_val, req0_rdy, req1_rdy} !== 3'b101 || memreq_msg !== m1) begin
         bad++; $display("FAIL conflict_c1 got=%b exp=101", {memreq_val, req0_rdy, req1_rdy});
      end
      tick();
      req1_val = 1'b0;
      memresp_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
      for (int k = 0; k < 2; k++) begin
         memresp_msg = make_resp(k == 0 ? m0 : m1);
         @(negedge clk);
         total++;
         if ({resp0_val, resp1_val} !== (k == 0 ? 2'b10 : 2'b01) || memresp_rdy !== 1'b1) begin
            bad++; $display("FAIL conflict_resp%0d got=%b rdy=%b", k, {resp0_val, resp1_val}, memresp_rdy);
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      int n0, n1, cyc;
      int got[$];
      int ex;
      do_reset();
      n0 = 6; n1 = 6; cyc = 0;
      memreq_rdy = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
      while (got.size() < 12 && cyc < 100) begin
         req0_val = (n0 > 0); req1_val = (n1 > 0);
         req0_msg = rand_req(); req1_msg = rand_req();
         memresp_val = (mem_q.size() > 0);
         memresp_msg = (mem_q.size() > 0) ? mem_q[0] : '0;
         @(negedge clk);
         if (memresp_val && memresp_rdy) void'(mem_q.pop_front());
         if (memreq_val && memreq_rdy) begin
            got.push_back(req1_rdy ? 1 : 0);
            if (req1_rdy) n1--; else n0--;
            mem_q.push_back(make_resp(memreq_msg));
         end
         tick();
         cyc++;
      end
      total++;
      if (got.size() != 12) begin
         bad++; $display("FAIL b2b_count got=%0d exp=12", got.size());
      end
      for (int i = 0; i < got.size(); i++) begin
`ifdef PLAB3_MEM_ARB_FIXED_PRIO_EN
         ex = (i < 6) ? 0 : 1;
`else
         ex = i % 2;
`endif
         total++;
         if (got[i] != ex) begin
            bad++; $display("FAIL b2b_order idx=%0d got=%0d exp=%0d", i, got[i], ex);
         end
      end
      clear_inputs();
   endtask

   task automatic test_full();
      do_reset();
      req0_val = 1'b1; memreq_rdy = 1'b1; resp0_rdy = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         req0_msg = rand_req();
         @(negedge clk);
         total++;
         if ({memreq_val, req0_rdy} !== 2'b11) begin
            bad++; $display("FAIL full_fill%0d got=%b exp=11", i, {memreq_val, req0_rdy});
         end
         tick();
      end
      @(negedge clk);
      total++;
      if ({memreq_val, req0_rdy, req1_rdy} !== 3'b000) begin
         bad++; $display("FAIL full_block got=%b exp=000", {memreq_val, req0_rdy, req1_rdy});
      end
      tick();
      memresp_val = 1'b1;
      @(negedge clk);
      total++;
      if ({memreq_val, req0_rdy, memresp_rdy} !== 3'b001) begin
         bad++; $display("FAIL full_pop_same_cycle got=%b exp=001", {memreq_val, req0_rdy, memresp_rdy});
      end
      tick();
      memresp_val = 1'b0;
      @(negedge clk);
      total++;
      if ({memreq_val, req0_rdy} !== 2'b11) begin
         bad++; $display("FAIL full_fifth got=%b exp=11", {memreq_val, req0_rdy});
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_backpressure();
      do_reset();
      req1_val = 1'b1; memreq_rdy = 1'b1;
      tick();
      req1_val = 1'b0;
      memresp_val = 1'b1; memresp_msg = make_resp(rand_req());
      resp0_rdy = 1'b1; resp1_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({resp0_val, resp1_val, memresp_rdy} !== 3'b010) begin
            bad++; $display("FAIL bp_hold%0d got=%b exp=010", i, {resp0_val, resp1_val, memresp_rdy});
         end
         tick();
      end
      resp1_rdy = 1'b1;
      @(negedge clk);
      total++;
      if ({resp0_val, resp1_val, memresp_rdy} !== 3'b011) begin
         bad++; $display("FAIL bp_release got=%b exp=011", {resp0_val, resp1_val, memresp_rdy});
      end
      tick();
      @(negedge clk);
      total++;
      if ({resp0_val, resp1_val, memresp_rdy} !== 3'b000) begin
         bad++; $display("FAIL bp_popped got=%b exp=000", {resp0_val, resp1_val, memresp_rdy});
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_async_reset();
      logic [5:0] obs;
      do_reset();
      req0_val = 1'b1; memreq_rdy = 1'b1;
      repeat (3) tick();
      req1_val = 1'b1; memresp_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
      #1;
      total++;
      if ({memreq_val, memresp_rdy} !== 2'b11) begin
         bad++; $display("FAIL areset_pre got=%b exp=11", {memreq_val, memresp_rdy});
      end
      reset = 1'b0;
      #1;
      obs = {memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy};
      total++;
      if (obs !== 6'b000000) begin
         bad++; $display("FAIL areset_drop got=%b exp=%b", obs, 6'b000000);
      end
      q_ids.delete(); mem_q.delete(); rr = 0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      obs = {memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy};
      total++;
      if (obs !== 6'b110000) begin
         bad++; $display("FAIL areset_after got=%b exp=%b", obs, 6'b110000);
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_random();
      int g, h;
      logic full, empty, e_mval, e_r0, e_r1, e_v0, e_v1, e_mrdy;
      logic [5:0] obs, exp_v;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         req0_val    = 1'($urandom_range(0, 1));
         req1_val    = 1'($urandom_range(0, 1));
         req0_msg    = rand_req();
         req1_msg    = rand_req();
         memreq_rdy  = ($urandom_range(0, 99) < 80);
         resp0_rdy   = ($urandom_range(0, 99) < 70);
         resp1_rdy   = ($urandom_range(0, 99) < 70);
         memresp_val = ($urandom_range(0, 99) < ((c % 200) < 100 ? 20 : 75));
         memresp_msg = (mem_q.size() > 0) ? mem_q[0] : make_resp(rand_req());

         full   = (q_ids.size() == DEPTH);
         empty  = (q_ids.size() == 0);
         g      = exp_grant(req0_val, req1_val);
         h      = empty ? 0 : q_ids[0];
         e_mval = (g >= 0) && !full;
         e_r0   = (g == 0) && memreq_rdy && !full;
         e_r1   = (g == 1) && memreq_rdy && !full;
         e_v0   = memresp_val && !empty && (h == 0);
         e_v1   = memresp_val && !empty && (h == 1);
         e_mrdy = !empty && ((h == 1) ? resp1_rdy : resp0_rdy);
         exp_v  = {e_mval, e_r0, e_r1, e_v0, e_v1, e_mrdy};

         @(negedge clk);
         obs = {memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy};
         total++;
         if (obs !== exp_v) begin
            bad++; $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", c, obs, exp_v);
         end
         if (e_mval) begin
            total++;
            if (memreq_msg !== (g == 1 ? req1_msg : req0_msg)) begin
               bad++; $display("FAIL rand_reqmsg cyc=%0d got=%h exp=%h", c, memreq_msg, (g == 1 ? req1_msg : req0_msg));
            end
         end
         total++;
         if (resp0_msg !== memresp_msg || resp1_msg !== memresp_msg) begin
            bad++; $display("FAIL rand_respmsg cyc=%0d got0=%h got1=%h exp=%h", c, resp0_msg, resp1_msg, memresp_msg);
         end

         if (memresp_val && e_mrdy) begin
            void'(q_ids.pop_front());
            void'(mem_q.pop_front());
         end
         if (e_mval && memreq_rdy) begin
            q_ids.push_back(g);
            mem_q.push_back(make_resp(g == 1 ? req1_msg : req0_msg));
`ifndef PLAB3_MEM_ARB_FIXED_PRIO_EN
            rr = 1 - g;
`endif
         end
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rr = 0;
      test_reset();
      test_single();
      test_conflict();
      test_back_to_back();
      test_full();
      test_backpressure();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
